// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP-1 RAM access controller.
package sap_pkg;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RAM_DEPTH = 16;

    typedef enum logic [3:0] {
        IDLE,
        M_SETUP,
        M_WRITE,
        M_HOLD,
        W_SETUP,
        W_WRITE,
        W_HOLD,
        R_SETUP,
        R_READ,
        DONE
    } state_e;

    function automatic logic is_write_st(input state_e s);
        return (s == M_WRITE) || (s == W_WRITE);
    endfunction

endpackage

// File: rtl/ram_acesso_ctrl_if.sv
// Front-panel / control-unit / RAM signal bundle for ram_acesso_ctrl.
interface ram_acesso_ctrl_if;
    import sap_pkg::*;

    logic              prog_mode;
    logic              btn_wr;
    logic [ADDR_W-1:0] dip_addr;
    logic              cpu_rd_req;
    logic              cpu_wr_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ack;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_in;
    logic              ram_out;
    logic              programm_run;
    logic [ADDR_W-1:0] man_addr;

    modport master (
        output prog_mode, btn_wr, dip_addr, cpu_rd_req, cpu_wr_req, cpu_addr,
        input  cpu_ack, busy, ram_addr, ram_in, ram_out, programm_run, man_addr
    );

    modport slave (
        input  prog_mode, btn_wr, dip_addr, cpu_rd_req, cpu_wr_req, cpu_addr,
        output cpu_ack, busy, ram_addr, ram_in, ram_out, programm_run, man_addr
    );

endinterface

// File: rtl/debounce_pulso.sv
// Button synchronizer + debounce counter; emits a one-cycle pulse on a debounced rising edge.
module debounce_pulso #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             w_diff;
    logic             w_done;

    // Counter tracks consecutive samples that disagree with the accepted level.
    assign w_diff  = r_sync[1] ^ r_level;
    assign w_done  = w_diff && (r_cnt == CNT_LAST);
    assign o_pulse = r_pulse;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= w_done && r_sync[1];
            if (!w_diff || w_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_level <= r_sync[1];
            end
        end
    end

endmodule

// File: rtl/ram_acesso_ctrl.sv
// Arbiter/sequencer sharing the SAP-1 16x8 RAM between the manual loader and the CPU.
// Optional AUTO_INC_EN: manual address becomes an auto-incrementing counter instead of dip_addr.
module ram_acesso_ctrl
    import sap_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    ram_acesso_ctrl_if.slave io_bus
);

    state_e            r_state, w_state_d;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_d;
    logic [ADDR_W-1:0] r_man_addr, w_man_addr_d;
    logic              r_man_pend, w_man_pend_d;
    logic              r_prun, w_prun_d;
    logic              r_ram_in, r_ram_out, r_cpu_ack;
    logic              w_btn_pulse;
    logic [ADDR_W-1:0] w_man_sel;

    debounce_pulso #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_btn  (io_bus.btn_wr),
        .o_pulse(w_btn_pulse)
    );

`ifdef AUTO_INC_EN
    assign w_man_sel = r_man_addr;
`else
    assign w_man_sel = io_bus.dip_addr;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_ram_addr_d = r_ram_addr;
        w_man_addr_d = r_man_addr;
        w_prun_d     = r_prun;
        // A new edge arriving in the same cycle as acceptance is kept as the next pending write.
        w_man_pend_d = r_man_pend | w_btn_pulse;
        case (r_state)
            IDLE: begin
                w_prun_d = ~io_bus.prog_mode;
                if (io_bus.prog_mode) begin
                    if (r_man_pend) begin
                        w_state_d    = M_SETUP;
                        w_ram_addr_d = w_man_sel;
                        w_man_addr_d = w_man_sel;
                        w_man_pend_d = w_btn_pulse;
                    end
                end else begin
                    w_man_pend_d = 1'b0;
                    if (io_bus.cpu_wr_req) begin
                        w_state_d    = W_SETUP;
                        w_ram_addr_d = io_bus.cpu_addr;
                    end else if (io_bus.cpu_rd_req) begin
                        w_state_d    = R_SETUP;
                        w_ram_addr_d = io_bus.cpu_addr;
                    end
                end
            end
            M_SETUP: w_state_d = M_WRITE;
            M_WRITE: w_state_d = M_HOLD;
            M_HOLD: begin
                w_state_d = IDLE;
`ifdef AUTO_INC_EN
                w_man_addr_d = r_man_addr + ADDR_W'(1);
`endif
            end
            W_SETUP: w_state_d = W_WRITE;
            W_WRITE: w_state_d = W_HOLD;
            W_HOLD:  w_state_d = DONE;
            R_SETUP: w_state_d = R_READ;
            R_READ:  w_state_d = DONE;
            DONE: begin
                if (!io_bus.cpu_rd_req && !io_bus.cpu_wr_req) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_ram_addr <= '0;
            r_man_addr <= '0;
            r_man_pend <= 1'b0;
            r_prun     <= 1'b0;
            r_ram_in   <= 1'b0;
            r_ram_out  <= 1'b0;
            r_cpu_ack  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_ram_addr <= w_ram_addr_d;
            r_man_addr <= w_man_addr_d;
            r_man_pend <= w_man_pend_d;
            r_prun     <= w_prun_d;
            r_ram_in   <= is_write_st(w_state_d);
            r_ram_out  <= (w_state_d == R_READ);
            r_cpu_ack  <= (w_state_d == W_HOLD) || (w_state_d == R_READ);
        end
    end

    assign io_bus.busy         = (r_state != IDLE);
    assign io_bus.ram_addr     = r_ram_addr;
    assign io_bus.ram_in       = r_ram_in;
    assign io_bus.ram_out      = r_ram_out;
    assign io_bus.cpu_ack      = r_cpu_ack;
    assign io_bus.programm_run = r_prun;
    assign io_bus.man_addr     = r_man_addr;

endmodule
